// File: rtl/dispatch_partial_ctrl.sv
// dispatch_partial_ctrl: in-order partial dispatch of a held rename bundle into IQ/AL/LSQ
// with saturating partial/full stall statistics.
module dispatch_partial_ctrl #(
   parameter int DISPATCH_WIDTH = 4,
   parameter int PKT_W          = 64,
   parameter int OCC_W          = 8,
   parameter int PERF_CNT_W     = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            recoverFlag_i,
   input  logic [DISPATCH_WIDTH-1:0]       renameValid_i,
   input  logic [DISPATCH_WIDTH*PKT_W-1:0] renamePkt_i,
   input  logic [DISPATCH_WIDTH-1:0]       isLoad_i,
   input  logic [DISPATCH_WIDTH-1:0]       isStore_i,
   output logic                            renameReady_o,
   input  logic [OCC_W-1:0]                iqCnt_i,
   input  logic [OCC_W-1:0]                alCnt_i,
   input  logic [OCC_W-1:0]                ldqCnt_i,
   input  logic [OCC_W-1:0]                stqCnt_i,
   input  logic [OCC_W-1:0]                iqSize_i,
   input  logic [OCC_W-1:0]                alSize_i,
   input  logic [OCC_W-1:0]                lsqSize_i,
   output logic [DISPATCH_WIDTH-1:0]       dispValid_o,
   output logic [DISPATCH_WIDTH*PKT_W-1:0] dispPkt_o,
   output logic [DISPATCH_WIDTH-1:0]       dispLoad_o,
   output logic [DISPATCH_WIDTH-1:0]       dispStore_o,
   output logic                            stallIq_o,
   output logic                            stallAl_o,
   output logic                            stallLdq_o,
   output logic                            stallStq_o,
   output logic [PERF_CNT_W-1:0]           partialCnt_o,
   output logic [PERF_CNT_W-1:0]           fullStallCnt_o
);
   localparam int W = DISPATCH_WIDTH;
   logic [W-1:0] pend_q, pend_d, ld_q, ld_d, st_q, st_d, disp;
   logic [W*PKT_W-1:0] pkt_q, pkt_d;
   logic [PERF_CNT_W-1:0] part_q, part_d, full_q, full_d;
   logic [OCC_W:0] n, l, s;
   logic ok, first, f_iq, f_al, f_ld, f_st, accept, active;
   logic stall_iq, stall_al, stall_ld, stall_st;
   // Cumulative sums are one bit wider than the occupancies so size<occupancy never wraps into a fit.
   always_comb begin
      n = '0;
      l = '0;
      s = '0;
      ok = 1'b1;
      first = 1'b1;
      disp = '0;
      f_iq = 1'b0;
      f_al = 1'b0;
      f_ld = 1'b0;
      f_st = 1'b0;
      {stall_iq, stall_al, stall_ld, stall_st} = '0;
      for (int i = 0; i < W; i++) begin
         n = n + (OCC_W+1)'(pend_q[i]);
         l = l + (OCC_W+1)'(pend_q[i] & ld_q[i]);
         s = s + (OCC_W+1)'(pend_q[i] & st_q[i]);
         f_iq = ({1'b0, iqCnt_i} + n) <= {1'b0, iqSize_i};
         f_al = ({1'b0, alCnt_i} + n) <= {1'b0, alSize_i};
         f_ld = ({1'b0, ldqCnt_i} + l) <= {1'b0, lsqSize_i};
         f_st = ({1'b0, stqCnt_i} + s) <= {1'b0, lsqSize_i};
         disp[i] = pend_q[i] & ok & f_iq & f_al & f_ld & f_st & ~recoverFlag_i & ~reset;
         if (pend_q[i] & ~disp[i] & first & ~reset) begin
            first = 1'b0;
            {stall_iq, stall_al, stall_ld, stall_st} = {~f_iq, ~f_al, ~f_ld, ~f_st};
         end
         ok = ok & ~(pend_q[i] & ~disp[i]);
      end
   end
   always_comb begin
      renameReady_o = ~reset & ~recoverFlag_i & ((pend_q & ~disp) == '0);
      accept = renameReady_o & (|renameValid_i);
      active = (|pend_q) & ~recoverFlag_i & ~reset;
      pend_d = recoverFlag_i ? '0 : accept ? renameValid_i : pend_q & ~disp;
      pkt_d = accept ? renamePkt_i : pkt_q;
      ld_d = accept ? isLoad_i : ld_q;
      st_d = accept ? isStore_i : st_q;
      part_d = (active & (|disp) & (disp != pend_q) & ~(&part_q)) ? part_q + 1'b1 : part_q;
      full_d = (active & ~(|disp) & ~(&full_q)) ? full_q + 1'b1 : full_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         part_q <= '0;
         full_q <= '0;
      end else begin
         pend_q <= pend_d;
         part_q <= part_d;
         full_q <= full_d;
      end
      pkt_q <= pkt_d;
      ld_q <= ld_d;
      st_q <= st_d;
   end
   assign dispValid_o = disp;
   assign dispPkt_o = reset ? '0 : pkt_q;
   assign dispLoad_o = disp & ld_q;
   assign dispStore_o = disp & st_q;
   assign stallIq_o = stall_iq;
   assign stallAl_o = stall_al;
   assign stallLdq_o = stall_ld;
   assign stallStq_o = stall_st;
   assign partialCnt_o = part_q;
   assign fullStallCnt_o = full_q;
endmodule

// File: tb/tb_dispatch_partial_ctrl.sv
// tb_dispatch_partial_ctrl: directed scenarios checked against a prefix-fit reference model
// every cycle, plus literal expectations for the key cycles.
module tb_dispatch_partial_ctrl;
   localparam int W = 4, PKT_W = 64, OCC_W = 8, PCW = 4;
   logic clk = 1'b0, reset, recov;
   logic [W-1:0] valid, ld, st, disp, dld, dst;
   logic [W*PKT_W-1:0] pkt, dpkt;
   logic [OCC_W-1:0] iqc, alc, ldqc, stqc, iqs, als, lsqs;
   logic ready, s_iq, s_al, s_ld, s_st;
   logic [PCW-1:0] part_cnt, full_cnt;
   int checks = 0, failures = 0;

   dispatch_partial_ctrl #(.DISPATCH_WIDTH(W), .PKT_W(PKT_W), .OCC_W(OCC_W), .PERF_CNT_W(PCW)) dut (
      .clk(clk), .reset(reset), .recoverFlag_i(recov), .renameValid_i(valid), .renamePkt_i(pkt),
      .isLoad_i(ld), .isStore_i(st), .renameReady_o(ready), .iqCnt_i(iqc), .alCnt_i(alc),
      .ldqCnt_i(ldqc), .stqCnt_i(stqc), .iqSize_i(iqs), .alSize_i(als), .lsqSize_i(lsqs),
      .dispValid_o(disp), .dispPkt_o(dpkt), .dispLoad_o(dld), .dispStore_o(dst),
      .stallIq_o(s_iq), .stallAl_o(s_al), .stallLdq_o(s_ld), .stallStq_o(s_st),
      .partialCnt_o(part_cnt), .fullStallCnt_o(full_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending lanes as an ordered list, dispatch the longest fitting prefix.
   logic [W-1:0] m_pend = '0, m_ld = '0, m_st = '0;
   logic [PKT_W-1:0] m_pkt [W];
   int m_part = 0, m_full = 0, lanes[$];

   function automatic logic [3:0] fails(int k);
      int nl = 0, ns = 0;
      for (int j = 0; j < k; j++) begin
         nl += int'(m_ld[lanes[j]]);
         ns += int'(m_st[lanes[j]]);
      end
      return {int'(stqc) + ns > int'(lsqs), int'(ldqc) + nl > int'(lsqs),
              int'(alc) + k > int'(als), int'(iqc) + k > int'(iqs)};
   endfunction

   always @(negedge clk) begin : model
      int kd, np;
      logic [W-1:0] e_disp;
      logic [3:0] e_stall;
      logic e_ready;
      assert ((valid & (valid + 4'd1)) == 4'd0) else $error("non-contiguous renameValid_i");
      lanes.delete();
      for (int i = 0; i < W; i++) if (m_pend[i]) lanes.push_back(i);
      np = lanes.size();
      kd = 0;
      if (!reset && !recov) while (kd < np && fails(kd + 1) == 4'd0) kd++;
      e_disp = '0;
      for (int j = 0; j < kd; j++) e_disp[lanes[j]] = 1'b1;
      e_stall = (!reset && kd < np) ? fails(kd + 1) : 4'd0;
      e_ready = !reset && !recov && kd == np;
      chk("m_disp", 64'(disp), 64'(e_disp));
      chk("m_ready", 64'(ready), 64'(e_ready));
      chk("m_load", 64'(dld), 64'(e_disp & m_ld));
      chk("m_store", 64'(dst), 64'(e_disp & m_st));
      chk("m_stall", 64'({s_st, s_ld, s_al, s_iq}), 64'(e_stall));
      chk("m_partial", 64'(part_cnt), 64'(m_part));
      chk("m_full", 64'(full_cnt), 64'(m_full));
      for (int i = 0; i < W; i++) begin
         if (reset) chk("m_pkt_rst", dpkt[i*PKT_W +: PKT_W], 64'd0);
         else if (e_disp[i]) chk("m_pkt", dpkt[i*PKT_W +: PKT_W], m_pkt[i]);
      end
      if (reset) begin
         m_pend = '0;
         m_part = 0;
         m_full = 0;
      end else if (recov) begin
         m_pend = '0;
      end else begin
         if (np > 0 && kd == 0) m_full = (m_full < 2**PCW - 1) ? m_full + 1 : m_full;
         if (kd > 0 && kd < np) m_part = (m_part < 2**PCW - 1) ? m_part + 1 : m_part;
         if (e_ready && valid != '0) begin
            m_pend = valid;
            m_ld = ld;
            m_st = st;
            for (int i = 0; i < W; i++) m_pkt[i] = pkt[i*PKT_W +: PKT_W];
         end else m_pend = m_pend & ~e_disp;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [W-1:0] v, input logic [W-1:0] l, input logic [W-1:0] s);
      valid = v;
      ld = l;
      st = s;
      for (int i = 0; i < W; i++) pkt[i*PKT_W +: PKT_W] = {$urandom, $urandom};
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      recov = 1'b0;
      {iqc, alc, ldqc, stqc} = '0;
      iqs = 8'd64;
      als = 8'd128;
      lsqs = 8'd32;
      offer(4'b1111, 4'b0100, 4'b0000);
      // T1 reset held over two edges
      @(negedge clk);
      chk("t1_rst_disp", 64'(disp), 64'd0);
      chk("t1_rst_ready", 64'(ready), 64'd0);
      chk("t1_rst_part", 64'(part_cnt), 64'd0);
      chk("t1_rst_full", 64'(full_cnt), 64'd0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t1_ready", 64'(ready), 64'd1);
      chk("t1_disp", 64'(disp), 64'd0);
      // T2 full fit, next bundle offered and accepted while draining
      step();
      offer(4'b1111, 4'b0000, 4'b0000);
      @(negedge clk);
      chk("t2_disp", 64'(disp), 64'b1111);
      chk("t2_load", 64'(dld), 64'b0100);
      chk("t2_ready", 64'(ready), 64'd1);
      // T3 IQ partial
      step();
      valid = '0;
      iqc = 8'd62;
      @(negedge clk);
      chk("t3_disp", 64'(disp), 64'b0011);
      chk("t3_stall_iq", 64'(s_iq), 64'd1);
      chk("t3_ready", 64'(ready), 64'd0);
      step();
      iqc = 8'd60;
      offer(4'b1111, 4'b0000, 4'b0011);
      @(negedge clk);
      chk("t3_disp2", 64'(disp), 64'b1100);
      chk("t3_ready2", 64'(ready), 64'd1);
      chk("t3_partial", 64'(part_cnt), 64'd1);
      // T4 STQ limited
      step();
      valid = '0;
      iqc = 8'd0;
      stqc = 8'd31;
      @(negedge clk);
      chk("t4_disp", 64'(disp), 64'b0001);
      chk("t4_stall_stq", 64'(s_st), 64'd1);
      step();
      stqc = 8'd32;
      @(negedge clk);
      chk("t4_disp_none", 64'(disp), 64'd0);
      chk("t4_full0", 64'(full_cnt), 64'd0);
      chk("t4_partial2", 64'(part_cnt), 64'd2);
      step();
      @(negedge clk);
      chk("t4_full1", 64'(full_cnt), 64'd1);
      // leave lanes 2,3 pending for the recovery test
      step();
      stqc = 8'd31;
      iqc = 8'd63;
      @(negedge clk);
      chk("t5_pre_disp", 64'(disp), 64'b0010);
      // T5 recovery mid-hold with a bundle offered that must be dropped
      step();
      recov = 1'b1;
      iqc = 8'd0;
      offer(4'b1111, 4'b0000, 4'b0000);
      @(negedge clk);
      chk("t5_disp", 64'(disp), 64'd0);
      chk("t5_ready", 64'(ready), 64'd0);
      step();
      recov = 1'b0;
      valid = '0;
      @(negedge clk);
      chk("t5_disp_after", 64'(disp), 64'd0);
      chk("t5_ready_after", 64'(ready), 64'd1);
      // T6 shrunk IQ and counter saturation
      step();
      reset = 1'b1;
      @(negedge clk);
      step();
      reset = 1'b0;
      iqs = 8'd8;
      iqc = 8'd12;
      offer(4'b1111, 4'b0000, 4'b0000);
      @(negedge clk);
      chk("t6_accept_ready", 64'(ready), 64'd1);
      step();
      valid = '0;
      repeat (20) begin
         @(negedge clk);
         chk("t6_disp", 64'(disp), 64'd0);
         step();
      end
      @(negedge clk);
      chk("t6_full_sat", 64'(full_cnt), 64'd15);
      chk("t6_stall_iq", 64'(s_iq), 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
